sklansky_sub_pipe: RTL and testbench

- Pipelined WIDTH-bit unsigned subtractor: diff = a - b, computed as a + ~b + 1 through a Sklansky parallel-prefix carry tree.
- Counterpart to the combinational Sklansky adder in the same datapath library.
- Two register stages with valid/ready handshake on both sides; accepts one operand pair per cycle under no backpressure.
- Used wherever the datapath needs a difference/compare result registered at a fixed latency.

---
 rtl/sklansky_sub_pipe.sv | 129 ++++++++++++
 tb/tb_sklansky_sub_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sklansky_sub_pipe.sv
// Two-stage pipelined unsigned subtractor (a + ~b + 1) built on a Sklansky prefix carry tree.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module sklansky_sub_pipe #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Node 0 carries the folded-in carry-in (g=1, p=0); node i+1 is operand bit i.
  localparam int N    = WIDTH + 1;
  localparam int LVL  = $clog2(N);
  localparam int LVL1 = LVL / 2;

  // Applies Sklansky levels [lo, hi) to a node vector and returns {G, P}.
  function automatic logic [2*N-1:0] prefix_levels(input logic [N-1:0] gi,
                                                   input logic [N-1:0] pi,
                                                   input int lo, input int hi);
    logic [N-1:0] g, p, gn, pn;
    int src;
    g = gi;
    p = pi;
    for (int k = 0; k < LVL; k++) begin
      if (k >= lo && k < hi) begin
        gn = g;
        pn = p;
        for (int j = 0; j < N; j++) begin
          if (((j >> k) & 1) == 1) begin
            src   = ((j >> k) << k) - 1;
            gn[j] = g[j] | (p[j] & g[src]);
            pn[j] = p[j] & p[src];
          end
        end
        g = gn;
        p = pn;
      end
    end
    return {g, p};
  endfunction

  function automatic logic [N-1:0] prefix_carries(input logic [N-1:0] gi,
                                                  input logic [N-1:0] pi,
                                                  input int lo, input int hi);
    logic [2*N-1:0] gp;
    gp = prefix_levels(gi, pi, lo, hi);
    return gp[2*N-1:N];
  endfunction

  logic             vld_p1, vld_p2;
  logic             adv1, adv2;
  logic [N-1:0]     g_p0, p_p0, g_s1, p_s1;
  logic [WIDTH-1:0] praw_p0;
  logic [N-1:0]     g_p1, p_p1;
  logic [WIDTH-1:0] praw_p1;
  logic [N-1:0]     c_p1;
  logic [WIDTH-1:0] diff_s2;
  logic             bout_s2;

  assign adv2      = ~vld_p2 | out_ready;
  assign adv1      = ~vld_p1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_p2;

  // ---- stage 0 -> 1: bit generate/propagate and first prefix levels
  assign praw_p0 = a ^ ~b;
  assign g_p0    = {a & ~b, 1'b1};
  assign p_p0    = {praw_p0, 1'b0};
  assign {g_s1, p_s1} = prefix_levels(g_p0, p_p0, 0, LVL1);

  always_ff @(posedge clk) begin
    if (in_valid && adv1) begin
      g_p1    <= g_s1;
      p_p1    <= p_s1;
      praw_p1 <= praw_p0;
    end
  end

`ifdef SUB_OVF_EN
  logic amsb_p1, bmsb_p1;
  always_ff @(posedge clk) begin
    if (in_valid && adv1) begin
      amsb_p1 <= a[WIDTH-1];
      bmsb_p1 <= b[WIDTH-1];
    end
  end
`endif

  // ---- stage 1 -> 2: remaining prefix levels, sum and borrow
  assign c_p1    = prefix_carries(g_p1, p_p1, LVL1, LVL);
  assign diff_s2 = praw_p1 ^ c_p1[WIDTH-1:0];
  assign bout_s2 = ~c_p1[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      if (adv1) vld_p1 <= in_valid;
      if (adv2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          diff <= diff_s2;
          bout <= bout_s2;
`ifdef SUB_OVF_EN
          ovf  <= (amsb_p1 ^ bmsb_p1) & (amsb_p1 ^ diff_s2[WIDTH-1]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sklansky_sub_pipe.sv
// Self-checking bench for sklansky_sub_pipe (WIDTH=5): directed table, stall/reset sequences, random stream.
module tb_sklansky_sub_pipe;
  localparam int W = 5;
  localparam int NRAND = 10000;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic         in_ready, out_valid, bout;
  logic [W-1:0] a, b, diff;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  sklansky_sub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t tab[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input logic [W-1:0] d, input logic bo, input logic ov);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_diff"}, 32'(diff), 32'(d));
    chk({name, "_bout"}, 32'(bout), 32'(bo));
`ifdef SUB_OVF_EN
    chk({name, "_ovf"}, 32'(ovf), 32'(ov));
`else
    if (ov === 1'bx) $display("unexpected X in vector table");
`endif
  endtask

  logic [W+1:0] q[$];
  logic [W+1:0] exp_e;
  int           sent, got, da, sa, sb, sd;
  logic         acc;

  initial begin
    tab[0]  = '{5'd20, 5'd7,  5'd13, 1'b0, 1'b1};
    tab[1]  = '{5'd3,  5'd5,  5'd30, 1'b1, 1'b0};
    tab[2]  = '{5'd0,  5'd31, 5'd1,  1'b1, 1'b0};
    tab[3]  = '{5'd31, 5'd31, 5'd0,  1'b0, 1'b0};
    tab[4]  = '{5'd0,  5'd1,  5'd31, 1'b1, 1'b0};
    tab[5]  = '{5'd31, 5'd0,  5'd31, 1'b0, 1'b0};
    tab[6]  = '{5'd16, 5'd1,  5'd15, 1'b0, 1'b1};
    tab[7]  = '{5'd5,  5'd3,  5'd2,  1'b0, 1'b0};
    tab[8]  = '{5'd10, 5'd4,  5'd6,  1'b0, 1'b0};
    tab[9]  = '{5'd1,  5'd2,  5'd31, 1'b1, 1'b0};
    tab[10] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0};
    tab[11] = '{5'd17, 5'd30, 5'd19, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single transaction latency
    a = 5'd20; b = 5'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_not_early", 32'(out_valid), 32'd0);
    tick();
    chk_res("lat", 5'd13, 1'b0, 1'b1);
    tick();
    chk("lat_drop", 32'(out_valid), 32'd0);

    // Back-to-back table stream, no backpressure
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) begin
        a = tab[i].a; b = tab[i].b; in_valid = 1'b1;
        #1;
        chk("tab_in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) chk_res($sformatf("tab%0d", i - 1), tab[i-1].d, tab[i-1].bo, tab[i-1].ov);
    end
    tick();
    chk("tab_drain", 32'(out_valid), 32'd0);

    // Backpressure: fill both stages, then hold with a third pair waiting
    out_ready = 1'b0;
    a = 5'd10; b = 5'd4; in_valid = 1'b1;
    tick();
    a = 5'd9; b = 5'd9;
    #1;
    chk("bp_in_ready1", 32'(in_ready), 32'd1);
    tick();
    a = 5'd1; b = 5'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready_full", 32'(in_ready), 32'd0);
      chk_res("bp_hold", 5'd6, 1'b0, 1'b0);
      tick();
    end
    // Full pipe: consume and accept on the same edge
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_sim", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_res("bp_r1", 5'd0, 1'b0, 1'b0);
    tick();
    chk_res("bp_r2", 5'd31, 1'b1, 1'b0);
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Reset with two pairs in flight
    out_ready = 1'b0;
    a = 5'd12; b = 5'd3; in_valid = 1'b1;
    tick();
    a = 5'd7; b = 5'd1;
    tick();
    in_valid = 1'b0;
    chk("mr_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_diff", 32'(diff), 32'd0);
    chk("mr_bout", 32'(bout), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_no_stale", 32'(out_valid), 32'd0);
    end

    // Random stream with random stalls against an arithmetic reference
    sent = 0; got = 0; in_valid = 1'b0;
    for (int cyc = 0; cyc < 60000 && got < NRAND; cyc++) begin
      if (!in_valid && sent < NRAND && $urandom_range(3) != 0) begin
        a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious", 32'(out_valid), 32'd0);
        end else begin
          exp_e = q.pop_front();
          chk("rand_diff", 32'(diff), 32'(exp_e[W-1:0]));
          chk("rand_bout", 32'(bout), 32'(exp_e[W]));
`ifdef SUB_OVF_EN
          chk("rand_ovf", 32'(ovf), 32'(exp_e[W+1]));
`endif
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        da = int'(a) - int'(b);
        sa = (int'(a) >= 16) ? int'(a) - 32 : int'(a);
        sb = (int'(b) >= 16) ? int'(b) - 32 : int'(b);
        sd = sa - sb;
        q.push_back({(sd > 15 || sd < -16), (a < b), W'(da)});
        sent++;
      end
      tick();
      if (acc) in_valid = 1'b0;
    end
    chk("rand_count", 32'(got), 32'(NRAND));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
